// File: rtl/spine_route_pkg.sv
// Shared types, fabric constants and default-port rule for the spine route lookup.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package spine_route_pkg;

    localparam int GROUP_ID_DEF   = 4;
    localparam int NUM_GROUPS_DEF = 8;
    localparam int GRP_W_DEF      = 4;
    localparam int LEAF_W_DEF     = 2;
    localparam int PORT_W_DEF     = 4;
    localparam int TAG_W_DEF      = 8;

    localparam int NUM_LEAFS    = 2**LEAF_W_DEF;
    localparam int NUM_PORTS    = NUM_LEAFS + NUM_GROUPS_DEF - 1;
    localparam int PORT_INVALID = 0;

    // Destination as carried on the request bus: group in the upper bits.
    typedef struct packed {
        logic [GRP_W_DEF-1:0]  group;
        logic [LEAF_W_DEF-1:0] leaf;
    } dest_t;

    // Uplink ports follow the local leaf ports; our own group has no uplink,
    // so groups above it shift down by one.
    function automatic int default_port(input int group, input int group_id,
                                        input int num_groups = NUM_GROUPS_DEF,
                                        input int num_leafs  = NUM_LEAFS);
        if (group == 0 || group == group_id || group > num_groups)
            return PORT_INVALID;
        else if (group < group_id)
            return num_leafs + group;
        else
            return num_leafs + group - 1;
    endfunction

endpackage

// File: rtl/spine_route_lookup_pipe_if.sv
// Request/response/config bundle between the ingress parser and the lookup pipe.
// Latency: n/a (wiring only).
// Backpressure: valid/ready on req and rsp; cfg is a bare strobe.
interface spine_route_lookup_pipe_if
    import spine_route_pkg::*;
#(
    parameter int GRP_W  = GRP_W_DEF,
    parameter int LEAF_W = LEAF_W_DEF,
    parameter int PORT_W = PORT_W_DEF,
    parameter int TAG_W  = TAG_W_DEF
);
    logic                    req_valid;
    logic                    req_ready;
    logic [GRP_W+LEAF_W-1:0] req_dest;
    logic [TAG_W-1:0]        req_tag;

    logic                    rsp_valid;
    logic                    rsp_ready;
    logic [PORT_W-1:0]       rsp_port;
    logic                    rsp_err;
    logic [TAG_W-1:0]        rsp_tag;

    logic                    cfg_we;
    logic [GRP_W-1:0]        cfg_group;
    logic [PORT_W-1:0]       cfg_port;

    modport master (
        output req_valid, req_dest, req_tag, rsp_ready, cfg_we, cfg_group, cfg_port,
        input  req_ready, rsp_valid, rsp_port, rsp_err, rsp_tag
    );

    modport slave (
        input  req_valid, req_dest, req_tag, rsp_ready, cfg_we, cfg_group, cfg_port,
        output req_ready, rsp_valid, rsp_port, rsp_err, rsp_tag
    );
endinterface

// File: rtl/spine_route_table.sv
// Inter-group port table: per-group egress port with reset defaults and one write port.
// Latency: combinational read; a write lands at the clock edge it is presented on.
// Backpressure: none, writes always complete.
module spine_route_table
    import spine_route_pkg::*;
#(
    parameter int GROUP_ID   = GROUP_ID_DEF,
    parameter int NUM_GROUPS = NUM_GROUPS_DEF,
    parameter int GRP_W      = GRP_W_DEF,
    parameter int LEAF_W     = LEAF_W_DEF,
    parameter int PORT_W     = PORT_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [GRP_W-1:0]  wr_group,
    input  logic [PORT_W-1:0] wr_port,
    input  logic [GRP_W-1:0]  rd_group,
    output logic [PORT_W-1:0] rd_port
);
    localparam int DEPTH = 2**GRP_W;

    logic [PORT_W-1:0] entry [DEPTH];
    logic              wr_ok;

    // Group 0, our own group and out-of-fabric groups have fixed meaning; protect them.
    assign wr_ok = wr_en && (wr_group != '0) && (wr_group != GRP_W'(GROUP_ID))
                         && (wr_group <= GRP_W'(NUM_GROUPS));

    // Entry storage: reload defaults on reset, otherwise take accepted writes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int g = 0; g < DEPTH; g++)
                entry[g] <= PORT_W'(default_port(g, GROUP_ID, NUM_GROUPS, 2**LEAF_W));
        end else if (wr_ok) begin
            entry[wr_group] <= wr_port;
        end
    end

    assign rd_port = entry[rd_group];

endmodule

// File: rtl/spine_route_lookup_pipe.sv
// Two-stage destination->egress-port lookup for one spine; optional stats via SPINE_ROUTE_STATS_EN.
// Latency: 2 cycles from request presentation to rsp_valid, 1 result per cycle.
// Backpressure: valid/ready; a stage advances when its successor is empty or draining.
module spine_route_lookup_pipe
    import spine_route_pkg::*;
#(
    parameter int GROUP_ID   = GROUP_ID_DEF,
    parameter int NUM_GROUPS = NUM_GROUPS_DEF,
    parameter int GRP_W      = GRP_W_DEF,
    parameter int LEAF_W     = LEAF_W_DEF,
    parameter int PORT_W     = PORT_W_DEF,
    parameter int TAG_W      = TAG_W_DEF
) (
    input  logic clk,
    input  logic rst_n,
    spine_route_lookup_pipe_if.slave bus
`ifdef SPINE_ROUTE_STATS_EN
    ,
    input  logic        stat_clr,
    output logic [15:0] stat_local,
    output logic [15:0] stat_remote,
    output logic [15:0] stat_err
`endif
);
    logic                    s1_valid;
    logic [GRP_W+LEAF_W-1:0] s1_dest;
    logic [TAG_W-1:0]        s1_tag;

    logic                    s2_valid;
    logic [PORT_W-1:0]       s2_port;
    logic                    s2_err;
    logic                    s2_local;
    logic [TAG_W-1:0]        s2_tag;

    logic                    s2_advance;
    logic [GRP_W-1:0]        s1_group;
    logic [LEAF_W-1:0]       s1_leaf;
    logic [PORT_W-1:0]       tbl_port;
    logic [PORT_W-1:0]       lk_port;
    logic                    lk_err;
    logic                    lk_local;

    assign s2_advance    = !s2_valid || bus.rsp_ready;
    assign bus.req_ready = rst_n && (!s1_valid || s2_advance);
    assign s1_group      = s1_dest[GRP_W+LEAF_W-1:LEAF_W];
    assign s1_leaf       = s1_dest[LEAF_W-1:0];

    spine_route_table #(
        .GROUP_ID   (GROUP_ID),
        .NUM_GROUPS (NUM_GROUPS),
        .GRP_W      (GRP_W),
        .LEAF_W     (LEAF_W),
        .PORT_W     (PORT_W)
    ) u_table (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (bus.cfg_we),
        .wr_group (bus.cfg_group),
        .wr_port  (bus.cfg_port),
        .rd_group (s1_group),
        .rd_port  (tbl_port)
    );

    // Resolve the S1 destination; the table read sees pre-edge contents, so a
    // write on the transfer edge only affects later requests.
    always_comb begin
        lk_port  = '0;
        lk_err   = 1'b0;
        lk_local = 1'b0;
        if (s1_group == GRP_W'(GROUP_ID)) begin
            lk_port  = PORT_W'(s1_leaf) + PORT_W'(1);
            lk_local = 1'b1;
        end else if (s1_group == '0 || s1_group > GRP_W'(NUM_GROUPS)) begin
            lk_err   = 1'b1;
        end else begin
            lk_port  = tbl_port;
            lk_err   = (tbl_port == PORT_W'(PORT_INVALID));
        end
    end

    // S1: capture a request whenever the slot is free or being vacated.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_dest  <= '0;
            s1_tag   <= '0;
        end else if (!s1_valid || s2_advance) begin
            s1_valid <= bus.req_valid;
            if (bus.req_valid) begin
                s1_dest <= bus.req_dest;
                s1_tag  <= bus.req_tag;
            end
        end
    end

    // S2: hold the result while the consumer stalls, else take S1's lookup.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            s2_port  <= '0;
            s2_err   <= 1'b0;
            s2_local <= 1'b0;
            s2_tag   <= '0;
        end else if (s2_advance) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_port  <= lk_port;
                s2_err   <= lk_err;
                s2_local <= lk_local;
                s2_tag   <= s1_tag;
            end
        end
    end

    assign bus.rsp_valid = s2_valid;
    assign bus.rsp_port  = s2_port;
    assign bus.rsp_err   = s2_err;
    assign bus.rsp_tag   = s2_tag;

`ifdef SPINE_ROUTE_STATS_EN
    logic rsp_fire;
    assign rsp_fire = s2_valid && bus.rsp_ready;

    // Per-class handshake counters; clear beats a same-cycle increment, values stick at max.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_local  <= '0;
            stat_remote <= '0;
            stat_err    <= '0;
        end else if (stat_clr) begin
            stat_local  <= '0;
            stat_remote <= '0;
            stat_err    <= '0;
        end else if (rsp_fire) begin
            if (s2_err) begin
                if (stat_err != 16'hFFFF) stat_err <= stat_err + 16'd1;
            end else if (s2_local) begin
                if (stat_local != 16'hFFFF) stat_local <= stat_local + 16'd1;
            end else begin
                if (stat_remote != 16'hFFFF) stat_remote <= stat_remote + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_spine_route_lookup_pipe.sv
// Directed bench for spine_route_lookup_pipe (GROUP_ID=4, 8 groups, 4 leafs).
// Latency: inputs driven and outputs sampled on the falling edge.
// Backpressure: exercised through rsp_ready stalls in the stream phase.
module tb_spine_route_lookup_pipe;
    import spine_route_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    spine_route_lookup_pipe_if bus ();

`ifdef SPINE_ROUTE_STATS_EN
    logic        stat_clr;
    logic [15:0] stat_local, stat_remote, stat_err;
    int          e_loc = 0, e_rem = 0, e_err = 0;
`endif

    spine_route_lookup_pipe dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef SPINE_ROUTE_STATS_EN
        ,
        .stat_clr    (stat_clr),
        .stat_local  (stat_local),
        .stat_remote (stat_remote),
        .stat_err    (stat_err)
`endif
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic dest_t mk(input int g, input int l);
        dest_t d;
        d.group = GRP_W_DEF'(g);
        d.leaf  = LEAF_W_DEF'(l);
        return d;
    endfunction

    // Single request through an idle pipe; entered and left on a falling edge.
    task automatic lookup(input string tag, input int g, input int l, input logic [7:0] t,
                          input int exp_port, input bit exp_err);
        int n;
        bus.req_valid = 1'b1;
        bus.req_dest  = mk(g, l);
        bus.req_tag   = t;
        bus.rsp_ready = 1'b1;
        #1;
        n = 0;
        while (!bus.req_ready && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk({tag, ".accept"}, 32'(n < 10), 1);
        @(negedge clk);
        bus.req_valid = 1'b0;
        n = 0;
        while (!bus.rsp_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk({tag, ".lat"},  n, 1);
        chk({tag, ".port"}, bus.rsp_port, exp_port);
        chk({tag, ".err"},  bus.rsp_err, exp_err);
        chk({tag, ".tag"},  bus.rsp_tag, t);
`ifdef SPINE_ROUTE_STATS_EN
        if (exp_err) e_err++;
        else if (g == GROUP_ID_DEF) e_loc++;
        else e_rem++;
`endif
        @(negedge clk);
    endtask

    task automatic cfg(input int g, input int p);
        bus.cfg_we    = 1'b1;
        bus.cfg_group = GRP_W_DEF'(g);
        bus.cfg_port  = PORT_W_DEF'(p);
        @(negedge clk);
        bus.cfg_we    = 1'b0;
    endtask

`ifdef SPINE_ROUTE_STATS_EN
    task automatic chk_stats(input string tag);
        chk({tag, ".local"},  stat_local,  e_loc);
        chk({tag, ".remote"}, stat_remote, e_rem);
        chk({tag, ".err"},    stat_err,    e_err);
    endtask
`endif

    int sg[6] = '{1, 3, 4, 8, 5, 4};
    int sl[6] = '{0, 3, 2, 1, 0, 0};
    int sp[6] = '{5, 7, 3, 11, 8, 1};

    initial begin
        int idx, got, stale;
        logic [7:0] rtag[$];
        int         rport[$];

        bus.req_valid = 1'b0;
        bus.req_dest  = '0;
        bus.req_tag   = '0;
        bus.rsp_ready = 1'b0;
        bus.cfg_we    = 1'b0;
        bus.cfg_group = '0;
        bus.cfg_port  = '0;
`ifdef SPINE_ROUTE_STATS_EN
        stat_clr = 1'b0;
`endif
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk("rst.rsp_valid", bus.rsp_valid, 0);
        chk("rst.req_ready", bus.req_ready, 0);
        chk("rst.rsp_port",  bus.rsp_port, 0);
        chk("rst.rsp_err",   bus.rsp_err, 0);
        chk("rst.rsp_tag",   bus.rsp_tag, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Default uplink ports.
        lookup("def1", 1, 0, 8'h01, 5, 0);
        lookup("def3", 3, 3, 8'h02, 7, 0);
        lookup("def5", 5, 1, 8'h03, 8, 0);
        lookup("def8", 8, 2, 8'h04, 11, 0);

        // Local leafs.
        for (int l = 0; l < 4; l++)
            lookup($sformatf("loc%0d", l), 4, l, 8'(8'h10 + l), l + 1, 0);

        // Invalid destinations and an unmapped entry.
        lookup("inv0", 0, 1, 8'h20, 0, 1);
        lookup("inv9", 9, 0, 8'h21, 0, 1);
        cfg(6, 0);
        lookup("unmap6", 6, 2, 8'h22, 0, 1);

        // Writes to protected groups have no effect.
        cfg(4, 9);
        cfg(0, 5);
        lookup("own4", 4, 2, 8'h23, 3, 0);
        lookup("grp0", 0, 0, 8'h24, 0, 1);

        // Back-pressure stream: consumer stalls for the first 5 cycles.
        idx = 0;
        got = 0;
        for (int c = 0; c < 30 && got < 6; c++) begin
            bus.rsp_ready = (c >= 5);
            bus.req_valid = (idx < 6);
            if (idx < 6) begin
                bus.req_dest = mk(sg[idx], sl[idx]);
                bus.req_tag  = 8'(idx + 1);
            end
            #1;
            if (c >= 2 && c <= 4) begin
                chk("bp.req_ready_low", bus.req_ready, 0);
                chk("bp.rsp_hold_vld",  bus.rsp_valid, 1);
                chk("bp.rsp_hold_tag",  bus.rsp_tag, 1);
            end
            if (bus.rsp_valid && bus.rsp_ready) begin
                rtag.push_back(bus.rsp_tag);
                rport.push_back(int'(bus.rsp_port));
                got++;
            end
            if (bus.req_valid && bus.req_ready) idx++;
            @(negedge clk);
        end
        bus.req_valid = 1'b0;
        chk("bp.count", got, 6);
        for (int i = 0; i < rtag.size(); i++) begin
            chk($sformatf("bp.tag%0d", i), rtag[i], i + 1);
            chk($sformatf("bp.port%0d", i), rport[i], sp[i]);
`ifdef SPINE_ROUTE_STATS_EN
            if (sg[i] == GROUP_ID_DEF) e_loc++;
            else e_rem++;
`endif
        end

        // Config write on the same edge the first {2,x} request moves S1->S2.
        bus.rsp_ready = 1'b1;
        bus.req_valid = 1'b1;
        bus.req_dest  = mk(2, 1);
        bus.req_tag   = 8'h41;
        @(negedge clk);
        bus.req_dest  = mk(2, 2);
        bus.req_tag   = 8'h42;
        bus.cfg_we    = 1'b1;
        bus.cfg_group = 4'd2;
        bus.cfg_port  = 4'd9;
        @(negedge clk);
        bus.cfg_we    = 1'b0;
        bus.req_valid = 1'b0;
        chk("race.old_vld",  bus.rsp_valid, 1);
        chk("race.old_tag",  bus.rsp_tag, 8'h41);
        chk("race.old_port", bus.rsp_port, 6);
        @(negedge clk);
        chk("race.new_vld",  bus.rsp_valid, 1);
        chk("race.new_tag",  bus.rsp_tag, 8'h42);
        chk("race.new_port", bus.rsp_port, 9);
        chk("race.new_err",  bus.rsp_err, 0);
        @(negedge clk);
`ifdef SPINE_ROUTE_STATS_EN
        e_rem += 2;
        chk_stats("stats");
        stat_clr = 1'b1;
        @(negedge clk);
        stat_clr = 1'b0;
        e_loc = 0; e_rem = 0; e_err = 0;
        chk_stats("stats_clr");
`endif

        // Reset with two requests in flight.
        bus.rsp_ready = 1'b0;
        bus.req_valid = 1'b1;
        bus.req_dest  = mk(1, 0);
        bus.req_tag   = 8'h51;
        @(negedge clk);
        bus.req_dest  = mk(3, 0);
        bus.req_tag   = 8'h52;
        @(negedge clk);
        bus.req_valid = 1'b0;
        chk("mid.pre_vld", bus.rsp_valid, 1);
        rst_n = 1'b0;
        #1;
        chk("mid.rsp_valid", bus.rsp_valid, 0);
        chk("mid.req_ready", bus.req_ready, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        bus.rsp_ready = 1'b1;
        stale = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (bus.rsp_valid) stale++;
        end
        chk("mid.stale", stale, 0);
`ifdef SPINE_ROUTE_STATS_EN
        chk_stats("stats_rst");
`endif
        lookup("post2", 2, 0, 8'h61, 6, 0);
        lookup("post6", 6, 1, 8'h62, 9, 0);
`ifdef SPINE_ROUTE_STATS_EN
        chk_stats("stats_end");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
